pcm_byte_packer: RTL

Downstream stage of the I2S capture/decimation path. It consumes each decimated signed PCM sample (IN_WIDTH bits, one-cycle valid strobe, about 12 kHz) and reduces it to OUT_WIDTH bits using round-half-up and signed saturation. It then serialises the result into bytes on a valid/ready stream that feeds the byte FIFO read out over SPI. Samples that arrive while the previous one is still being emitted are dropped and counted; the upstream strobe is never stalled.

---
 rtl/pcm_pkg.sv | 37 +++
 rtl/pcm_round_sat.sv | 50 +++++
 rtl/pcm_byte_packer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pcm_pkg.sv
// Shared definitions for the PCM byte packer: FSM states, derived sizes and
// the width of the dropped-sample counter.
package pcm_pkg;

  // Packer FSM: waiting for a sample, or serialising the held sample.
  typedef enum logic [0:0] {
    PCM_IDLE = 1'b0,
    PCM_SEND = 1'b1
  } pcm_state_e;

  // Width of the saturating dropped-sample counter.
  localparam int DROP_CNT_W = 16;

  // Default geometry of the capture path.
  localparam int DEF_IN_WIDTH  = 24;
  localparam int DEF_OUT_WIDTH = 16;

  // Number of LSBs removed by the reduction.
  function automatic int pcm_diff(input int in_w, input int out_w);
    return in_w - out_w;
  endfunction

  // Number of bytes emitted per reduced sample.
  function automatic int pcm_nbytes(input int out_w);
    return out_w / 8;
  endfunction

  // Width of the byte index; at least one bit even for single-byte samples.
  function automatic int pcm_idx_w(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

  // Derived constants for the default geometry.
  localparam int DIFF   = DEF_IN_WIDTH - DEF_OUT_WIDTH;
  localparam int NBYTES = DEF_OUT_WIDTH / 8;

endpackage

// File: rtl/pcm_round_sat.sv
// Combinational reduction of a signed IN_WIDTH sample to OUT_WIDTH bits:
// round-half-up on the discarded LSBs, then signed saturation.
module pcm_round_sat
  import pcm_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  i_sample,
  output logic [OUT_WIDTH-1:0] o_sample
);

  localparam int DIFF_W = pcm_diff(IN_WIDTH, OUT_WIDTH);

  generate
    if (DIFF_W == 0) begin : g_pass
      // Same width in and out: nothing to round or clip.
      assign o_sample = i_sample;
    end else begin : g_reduce
      // Half of one output LSB, expressed in input LSBs.
      localparam logic [IN_WIDTH:0] RND = (IN_WIDTH+1)'(1) << (DIFF_W - 1);
      // Signed output range expressed at IN_WIDTH+1 bits.
      localparam logic signed [IN_WIDTH:0] MAX_V =
        $signed({{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
      localparam logic signed [IN_WIDTH:0] MIN_V =
        $signed({{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

      logic signed [IN_WIDTH:0] w_ext;
      logic signed [IN_WIDTH:0] w_sum;
      logic signed [IN_WIDTH:0] w_shift;

      // One guard bit keeps the rounding add from wrapping at full scale.
      assign w_ext   = $signed({i_sample[IN_WIDTH-1], i_sample});
      assign w_sum   = w_ext + $signed(RND);
      assign w_shift = w_sum >>> DIFF_W;

      // Clip the rounded value into the signed OUT_WIDTH range.
      always_comb begin
        if (w_shift > MAX_V) begin
          o_sample = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (w_shift < MIN_V) begin
          o_sample = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
          o_sample = w_shift[OUT_WIDTH-1:0];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pcm_byte_packer.sv
// Reduces each incoming PCM sample and serialises it as bytes on a
// valid/ready stream. Samples arriving while a previous sample is still
// being sent are dropped and counted; pcm_valid is never back-pressured.
//
// Handshake: a byte moves when byte_valid & byte_ready are both high at a
// rising clk edge. Once byte_valid rises, it and byte_out stay constant
// until that transfer happens.
module pcm_byte_packer
  import pcm_pkg::*;
#(
  parameter int   IN_WIDTH  = DEF_IN_WIDTH,
  parameter int   OUT_WIDTH = DEF_OUT_WIDTH,
  parameter logic MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_WIDTH-1:0]   pcm_in,
  input  logic                  pcm_valid,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  overflow,
  input  logic                  clear_overflow,
  output logic [DROP_CNT_W-1:0] dropped_count,
  output logic                  dbg_state
);

  localparam int NB    = pcm_nbytes(OUT_WIDTH);
  localparam int IDX_W = pcm_idx_w(NB);

  pcm_state_e            r_state;
  logic [OUT_WIDTH-1:0]  r_hold;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic [OUT_WIDTH-1:0]  w_reduced;
  logic                  w_send;
  logic                  w_last;
  logic                  w_drop;
  logic [7:0]            w_byte;

  pcm_round_sat #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_round_sat (
    .i_sample (pcm_in),
    .o_sample (w_reduced)
  );

  assign w_send = (r_state == PCM_SEND);
  assign w_last = (r_idx == IDX_W'(NB - 1));
  // Any strobe while busy is lost, including the final-transfer cycle.
  assign w_drop = pcm_valid & w_send;

  // Capture a sample when idle, then step through its bytes on transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PCM_IDLE;
      r_hold  <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        PCM_IDLE: begin
          if (pcm_valid) begin
            r_hold  <= w_reduced;
            r_idx   <= '0;
            r_state <= PCM_SEND;
          end
        end
        PCM_SEND: begin
          if (byte_ready) begin
            if (w_last) begin
              r_idx   <= '0;
              r_state <= PCM_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= PCM_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow and saturating drop counter; a clear beats a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != {DROP_CNT_W{1'b1}}) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  // Pick byte r_idx of the held sample in the configured order.
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (r_idx == IDX_W'(i)) begin
        if (MSB_FIRST) begin
          w_byte = r_hold[OUT_WIDTH-1-8*i -: 8];
        end else begin
          w_byte = r_hold[8*i +: 8];
        end
      end
    end
  end

  // Stream outputs; the byte bus reads zero whenever nothing is offered.
  always_comb begin
    byte_valid = w_send;
    byte_out   = w_send ? w_byte : 8'h00;
  end

  assign overflow      = r_overflow;
  assign dropped_count = r_drop_cnt;
  assign dbg_state     = r_state;

endmodule
